// File: rtl/lod_pkg.sv
// Shared constants and helpers for the leading-one detector family.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package lod_pkg;

    // Default operand width used by lod_reg when no override is given.
    localparam int LOD_WIDTH_DEF = 64;

    // Width of the leading-zero count for a WIDTH-bit operand.
    // A WIDTH-bit operand has counts 0..WIDTH-1, so log2(WIDTH) bits suffice;
    // the all-zero case is signalled separately by the valid flag.
    function automatic int zp_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/lod_tree.sv
// Combinational leading-one detector: P = zeros above the MSB one, V = any one.
// Latency: 0 cycles (purely combinational, log2(WIDTH) merge levels).
// Backpressure: none; output follows the operand continuously.
module lod_tree
    import lod_pkg::*;
#(
    parameter int WIDTH = LOD_WIDTH_DEF
) (
    input  logic [WIDTH-1:0]           B,
    output logic [zp_width(WIDTH)-1:0] P,
    output logic                       V
);

    localparam int PW = zp_width(WIDTH);

    generate
        if (WIDTH == 2) begin : g_leaf
            // Leaf pair: the count is 1 exactly when the upper bit is clear.
            // For an all-zero pair the count is irrelevant (V=0) and the parent
            // selects the other half or the caller masks it with V.
            always_comb begin
                V = B[1] | B[0];
                P = ~B[1];
            end
        end else begin : g_node
            localparam int HW = WIDTH / 2;

            logic [PW-2:0] p_hi;
            logic [PW-2:0] p_lo;
            logic          v_hi;
            logic          v_lo;

            lod_tree #(.WIDTH(HW)) u_hi (
                .B (B[WIDTH-1:HW]),
                .P (p_hi),
                .V (v_hi)
            );

            lod_tree #(.WIDTH(HW)) u_lo (
                .B (B[HW-1:0]),
                .P (p_lo),
                .V (v_lo)
            );

            // Merge: an upper-half one wins; otherwise the whole upper half is
            // zeros, so the count is HW plus the lower-half count (MSB set).
            // When both halves are empty the lower leaf counts cascade to give
            // {1,1,..} patterns; force the all-zero result to P=0 explicitly.
            always_comb begin
                V = v_hi | v_lo;
                if (v_hi) begin
                    P = {1'b0, p_hi};
                end else if (v_lo) begin
                    P = {1'b1, p_lo};
                end else begin
                    P = '0;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/lod_reg.sv
// Registered leading-one detector: ZP = leading-zero count of B, ZV = B nonzero.
// Latency: 1 cycle (B before edge N appears after edge N), one operand per cycle.
// Backpressure: none; no enable, results overwrite every cycle.
module lod_reg
    import lod_pkg::*;
#(
    parameter int WIDTH = LOD_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           B,
    output logic [zp_width(WIDTH)-1:0] ZP,
    output logic                       ZV
);

    localparam int PW = zp_width(WIDTH);

    logic [PW-1:0] p;
    logic          v;

    lod_tree #(.WIDTH(WIDTH)) u_tree (
        .B (B),
        .P (p),
        .V (v)
    );

    // Capture the tree result every edge; reset clears it asynchronously so a
    // pending result never leaks out while the block is held in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ZP <= '0;
            ZV <= 1'b0;
        end else begin
            ZP <= p;
            ZV <= v;
        end
    end

endmodule

// File: tb/tb_lod_reg.sv
module tb_lod_reg;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] B;
    logic [5:0]   ZP;
    logic         ZV;

    int n_checks = 0;
    int n_pass   = 0;

    lod_reg #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .B     (B),
        .ZP    (ZP),
        .ZV    (ZV)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] b;
        logic [5:0]   zp;
        logic         zv;
    } vec_t;

    // Reference: scan down from the MSB and count zeros until the first one.
    function automatic void ref_lod(input logic [W-1:0] b,
                                    output logic [5:0] zp, output logic zv);
        int cnt;
        cnt = 0;
        zv  = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (b[i]) begin
                zv = 1'b1;
                break;
            end
            cnt++;
        end
        zp = zv ? 6'(cnt) : 6'd0;
    endfunction

    task automatic check(input string name, input logic [5:0] exp_zp, input logic exp_zv);
        n_checks++;
        if (ZP === exp_zp && ZV === exp_zv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got ZP=%0d ZV=%b, expected ZP=%0d ZV=%b",
                     name, ZP, ZV, exp_zp, exp_zv);
        end
    endtask

    // Present an operand between edges, then sample just after the next edge.
    task automatic apply(input logic [W-1:0] b);
        @(negedge clk);
        B = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t          vecs[6];
        logic [5:0]    ezp;
        logic          ezv;
        logic [31:0]   r;
        logic [W-1:0]  rb;
        logic [W-1:0]  one;

        vecs[0] = '{"zero",      64'h0000_0000_0000_0000, 6'd0,  1'b0};
        vecs[1] = '{"lsb_only",  64'h0000_0000_0000_0001, 6'd63, 1'b1};
        vecs[2] = '{"msb_only",  64'h8000_0000_0000_0000, 6'd0,  1'b1};
        vecs[3] = '{"mixed_32",  64'h0000_0000_8000_1234, 6'd32, 1'b1};
        vecs[4] = '{"mixed_56",  64'h0000_0000_0000_00F0, 6'd56, 1'b1};
        vecs[5] = '{"mixed_8",   64'h00FF_0000_0000_0001, 6'd8,  1'b1};

        // Reset held with an all-ones operand: outputs stay cleared across edges.
        rst_n = 1'b0;
        B     = '1;
        #1;
        check("reset_t0", 6'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", 6'd0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", 6'd0, 1'b1);

        // Directed table.
        foreach (vecs[i]) begin
            apply(vecs[i].b);
            check(vecs[i].name, vecs[i].zp, vecs[i].zv);
        end

        // Walking one, back to back.
        for (int k = 0; k < W; k++) begin
            one = 64'd1 << k;
            apply(one);
            check($sformatf("walk_%0d", k), 6'(63 - k), 1'b1);
        end

        // Result holds until the next edge even when B changes underneath.
        apply(64'h0000_0000_0001_0000);
        @(negedge clk);
        B = 64'h8000_0000_0000_0000;
        #1;
        check("hold_until_edge", 6'd47, 1'b1);
        @(posedge clk);
        #1;
        check("hold_next_edge", 6'd0, 1'b1);

        // Random sign-extended operands against the reference scan.
        for (int n = 0; n < 256; n++) begin
            r  = $urandom;
            if (n % 4 == 0) r = r >> $urandom_range(0, 31);
            rb = {{32{r[31]}}, r};
            ref_lod(rb, ezp, ezv);
            apply(rb);
            check($sformatf("rand_%0d_%h", n, rb), ezp, ezv);
        end

        // Asynchronous reset mid-cycle while a valid result is showing.
        apply(64'h0000_0000_0000_0001);
        check("pre_async", 6'd63, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", 6'd0, 1'b0);
        @(posedge clk);
        #1;
        check("async_hold", 6'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        B = 64'h0000_0000_0000_00F0;
        @(posedge clk);
        #1;
        check("after_async", 6'd56, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
